// File: rtl/sobol_fp16_scheduler_pkg.sv
// Shared types, default sizes and helpers for the Sobol FP16 scheduler.
// Holds the FSM state enum and the trailing-zero count used to select direction numbers.
package sobol_pkg;

    localparam int NUM_DIM    = 4;
    localparam int IDX_W      = 16;
    localparam int FP_EXP_W   = 5;
    localparam int FP_MAN_W   = 11;
    localparam int FP_MIN_EXP = 10;

    typedef enum logic [0:0] {IDLE, RUN} state_t;

    // Callers zero-extend an IDX_W-bit index, so this equals ctz over IDX_W bits.
    function automatic logic [4:0] ctz(input logic [31:0] v);
        logic [4:0] r;
        r = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) r = 5'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/sobol_fp16_scheduler_cvt.sv
// Shared INT32 -> FP16 converter: exponent is the MSO index clamped at FP_MIN_EXP,
// mantissa is the 11 bits starting at that position.
module sobol_fp16_scheduler_cvt
    import sobol_pkg::*;
(
    input  logic [31:0]                  x,
    output logic [FP_EXP_W+FP_MAN_W-1:0] fp16
);

    function automatic logic [FP_EXP_W+FP_MAN_W-1:0] int_to_fp16(input logic [31:0] v);
        logic [FP_EXP_W-1:0] e;
        logic [31:0]         sh;
        e = FP_EXP_W'(FP_MIN_EXP);
        for (int i = FP_MIN_EXP + 1; i < 32; i++) begin
            if (v[i]) e = FP_EXP_W'(i);
        end
        sh = v >> (e - FP_EXP_W'(FP_MIN_EXP));
        return {e, sh[FP_MAN_W-1:0]};
    endfunction

    assign fp16 = int_to_fp16(x);

endmodule

// File: rtl/sobol_fp16_scheduler.sv
// NUM_DIM-dimensional Gray-code Sobol sequencer streaming FP16 samples dim-by-dim
// through one shared converter over a valid/ready port.
module sobol_fp16_scheduler #(
    parameter int  NUM_DIM = sobol_pkg::NUM_DIM,
    parameter int  IDX_W   = sobol_pkg::IDX_W,
    localparam int DIM_W   = $clog2(NUM_DIM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [DIM_W-1:0] cfg_dim,
    input  logic [4:0]       cfg_bit,
    input  logic [31:0]      cfg_data,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_fp16,
    output logic [DIM_W-1:0] out_dim,
    output logic             out_last,
    output logic [IDX_W-1:0] out_idx
);
    import sobol_pkg::*;

    state_t           state, state_nxt;
    logic [31:0]      v_tab [NUM_DIM][32];
    logic [31:0]      x_reg [NUM_DIM];
    logic [DIM_W-1:0] dptr;
    logic [IDX_W-1:0] idx;
    logic             stop_pend;
    logic             done_q;
    logic             xfer, last_dim, run_end;
    logic [IDX_W-1:0] idx_inc;
    logic [4:0]       vsel;
    logic [31:0]      x_cur;

    assign last_dim = (dptr == DIM_W'(NUM_DIM - 1));
    assign xfer     = (state == RUN) && out_ready;
    // A run ends only on a point boundary: after the last dim of the final or stop-requested point.
    assign run_end  = xfer && last_dim && ((&idx) || stop_pend);
    assign idx_inc  = idx + IDX_W'(1);
    assign vsel     = ctz(32'(idx_inc));
    assign x_cur    = x_reg[dptr];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (run_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dptr      <= '0;
            idx       <= '0;
            stop_pend <= 1'b0;
            done_q    <= 1'b0;
            for (int d = 0; d < NUM_DIM; d++) begin
                x_reg[d] <= '0;
                for (int k = 0; k < 32; k++) v_tab[d][k] <= '0;
            end
        end else begin
            state  <= state_nxt;
            done_q <= run_end;
            if (state == IDLE) begin
                stop_pend <= 1'b0;
                if (cfg_we) v_tab[cfg_dim][cfg_bit] <= cfg_data;
                if (start) begin
                    dptr <= '0;
                    idx  <= '0;
                    for (int d = 0; d < NUM_DIM; d++) x_reg[d] <= '0;
                end
            end else begin
                if (stop) stop_pend <= 1'b1;
                if (run_end) begin
                    stop_pend <= 1'b0;
                end else if (xfer) begin
                    if (!last_dim) begin
                        dptr <= dptr + DIM_W'(1);
                    end else begin
                        // Antonov-Saleev step: all dims advance together at the point boundary.
                        dptr <= '0;
                        idx  <= idx_inc;
                        for (int d = 0; d < NUM_DIM; d++) x_reg[d] <= x_reg[d] ^ v_tab[d][vsel];
                    end
                end
            end
        end
    end

    sobol_fp16_scheduler_cvt u_cvt (
        .x    (x_cur),
        .fp16 (out_fp16)
    );

    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign out_valid = (state == RUN);
    assign out_dim   = dptr;
    assign out_last  = last_dim;
    assign out_idx   = idx;

endmodule

// File: tb/tb_sobol_fp16_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared every cycle
// against a point/dimension-level model that forms samples from the Gray-code closed form.
module tb_sobol_fp16_scheduler;

    localparam int ND   = 4;
    localparam int IW   = 3;
    localparam int NPTS = 1 << IW;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_dim = '0;
    logic [4:0]  cfg_bit = '0;
    logic [31:0] cfg_data = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        out_ready = 1'b0;
    logic        busy, done, out_valid, out_last;
    logic [15:0] out_fp16;
    logic [1:0]  out_dim;
    logic [2:0]  out_idx;

    sobol_fp16_scheduler #(.NUM_DIM(ND), .IDX_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_dim   (cfg_dim),
        .cfg_bit   (cfg_bit),
        .cfg_data  (cfg_data),
        .start     (start),
        .stop      (stop),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_fp16  (out_fp16),
        .out_dim   (out_dim),
        .out_last  (out_last),
        .out_idx   (out_idx)
    );

    always #5 clk = ~clk;

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  chk_en  = 1'b0;

    logic [31:0] mv [ND][32];
    bit          m_busy = 1'b0, m_done = 1'b0, m_sp = 1'b0, m_fin;
    int          m_dim = 0, m_idx = 0;

    logic [15:0] t1_exp [4] = '{16'h5000, 16'hFC00, 16'hFE00, 16'hF400};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] fp16_ref(input logic [31:0] x);
        int e;
        if (x == 32'd0) return 16'h5000;
        e = 31;
        while (!x[e]) e--;
        if (e < 10) e = 10;
        return {5'(e), 11'(x >> (e - 10))};
    endfunction

    // Point i of a Gray-code Sobol run is the XOR of V[k] over the set bits of gray(i).
    function automatic logic [15:0] sample_ref(input int d, input int i);
        logic [31:0] x;
        int          g;
        x = '0;
        g = i ^ (i >> 1);
        for (int k = 0; k < IW; k++) if (g[k]) x = x ^ mv[d][k];
        return fp16_ref(x);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_sp = 0; m_dim = 0; m_idx = 0;
            for (int d = 0; d < ND; d++) for (int k = 0; k < 32; k++) mv[d][k] = '0;
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (cfg_we) mv[cfg_dim][cfg_bit] = cfg_data;
                if (start) begin m_busy = 1; m_idx = 0; m_dim = 0; end
                m_sp = 0;
            end else begin
                m_fin = out_ready && (m_dim == ND - 1) && (m_idx == NPTS - 1 || m_sp);
                if (stop) m_sp = 1;
                if (m_fin) begin
                    m_busy = 0; m_done = 1; m_sp = 0;
                end else if (out_ready) begin
                    if (m_dim < ND - 1) m_dim++;
                    else begin m_dim = 0; m_idx++; end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, m_busy);
            check("out_valid", out_valid, m_busy);
            check("done", done, m_done);
            if (m_busy) begin
                check("out_dim", out_dim, m_dim);
                check("out_idx", out_idx, m_idx);
                check("out_last", out_last, m_dim == ND - 1);
                check("out_fp16", out_fp16, sample_ref(m_dim, m_idx));
            end
        end
    end

    task automatic load(input int d, input int k, input logic [31:0] data);
        cfg_we = 1; cfg_dim = 2'(d); cfg_bit = 5'(k); cfg_data = data;
        @(negedge clk);
        cfg_we = 0;
    endtask

    task automatic wait_for(input int d, input int i, input int limit, output bit ok);
        ok = 0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (out_valid && out_dim == 2'(d) && out_idx == 3'(i)) begin ok = 1; break; end
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL wait_sample: dim %0d idx %0d not seen, required within %0d cycles", d, i, limit);
        end
    endtask

    task automatic end_run();
        stop = 1;
        @(negedge clk);
        stop = 0;
        for (int c = 0; c < 40; c++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check("end_run_idle", busy, 0);
    endtask

    task automatic kick();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        int cnt, ld, li;

        // reset state
        rst = 1;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        rst = 0;
        chk_en = 1;

        // 1: single-dim direction numbers, known sample values
        for (int k = 0; k < 32; k++) load(0, k, 32'h8000_0000 >> k);
        out_ready = 1;
        kick();
        check("start_latency", out_valid, 1);
        check("t1_idx0", out_fp16, t1_exp[0]);
        for (int i = 1; i < 4; i++) begin
            wait_for(0, i, 20, ok);
            if (ok) check("t1_sample", out_fp16, t1_exp[i]);
        end
        end_run();

        // 2: backpressure holds the sample, then dims stream in order
        for (int d = 1; d < ND; d++) for (int k = 0; k < 3; k++) load(d, k, $urandom);
        out_ready = 0;
        kick();
        for (int c = 0; c < 5; c++) begin
            check("hold_fp16", out_fp16, 16'h5000);
            check("hold_dim", out_dim, 0);
            check("hold_idx", out_idx, 0);
            @(negedge clk);
        end
        out_ready = 1;
        for (int k = 0; k < ND; k++) begin
            check("seq_dim", out_dim, k);
            check("seq_last", out_last, k == ND - 1);
            @(negedge clk);
        end
        end_run();

        // 3: stop during dim1 transfer of idx 2
        kick();
        wait_for(1, 2, 40, ok);
        stop = 1;
        @(negedge clk);
        stop = 0;
        check("stop_dim2", out_dim, 2);
        check("stop_idx2", out_idx, 2);
        @(negedge clk);
        check("stop_dim3", out_dim, 3);
        @(negedge clk);
        check("stop_done", done, 1);
        check("stop_busy", busy, 0);
        check("stop_valid", out_valid, 0);
        @(negedge clk);
        check("stop_done_pulse", done, 0);

        // 4: full run of 2^IDX_W points ends without wrapping
        kick();
        cnt = 0; ld = -1; li = -1;
        for (int c = 0; c < 100; c++) begin
            if (out_valid && out_ready) begin cnt++; ld = out_dim; li = out_idx; end
            @(negedge clk);
            if (!busy) break;
        end
        check("full_count", cnt, 32);
        check("full_last_idx", li, 7);
        check("full_last_dim", ld, 3);
        check("full_done", done, 1);
        check("full_valid", out_valid, 0);

        // 5: config writes ignored in RUN, honoured together with start
        load(1, 0, 32'h0000_0001);
        kick();
        load(1, 0, 32'hFFFF_FFFF);
        wait_for(1, 1, 20, ok);
        if (ok) check("cfg_run_ignored", out_fp16, 16'h5001);
        end_run();
        cfg_we = 1; cfg_dim = 2'd1; cfg_bit = 5'd0; cfg_data = 32'hFFFF_FFFF;
        start = 1;
        @(negedge clk);
        cfg_we = 0; start = 0;
        wait_for(1, 1, 20, ok);
        if (ok) check("cfg_with_start", out_fp16, 16'hFFFF);
        end_run();

        // 6: reset mid-run clears table and drops the sample
        out_ready = 0;
        kick();
        check("pre_rst_valid", out_valid, 1);
        rst = 1;
        @(negedge clk);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        rst = 0;
        out_ready = 1;
        kick();
        for (int c = 0; c < 16; c++) begin
            check("cleared_sample", out_fp16, 16'h5000);
            @(negedge clk);
        end
        end_run();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            out_ready = ($urandom % 4) != 0;
            stop      = ($urandom % 40) == 0;
            start     = ($urandom % 8) == 0;
            cfg_we    = ($urandom % 3) == 0;
            cfg_dim   = 2'($urandom % ND);
            cfg_bit   = ($urandom % 2) ? 5'($urandom % 3) : 5'($urandom % 32);
            cfg_data  = ($urandom % 2) ? $urandom : ($urandom >> ($urandom % 32));
            rst       = ($urandom % 400) == 0;
            @(negedge clk);
        end
        rst = 0; start = 0; cfg_we = 0; out_ready = 1;
        end_run();

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
